// File: rtl/fixp_acc_stream.sv
// Streaming unsigned fixed-point packet accumulator, split into two half-width add stages.
// Latency: last beat accepted in T -> result valid in T+2; one beat per cycle inside a packet.
// Backpressure: s_tready drops for the bubble after a last beat and stays low until the result is taken.
module fixp_acc_stream #(
    parameter int DATA_WIDTH  = 128,
    parameter int COUNT_WIDTH = 16,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                   axis_aclk,
    input  logic                   axis_aresetn,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [DATA_WIDTH-1:0]  m_tdata,
    output logic [COUNT_WIDTH-1:0] m_tcount,
    output logic                   m_tuser,
    output logic                   m_tvalid,
    input  logic                   m_tready
);

    localparam int HW = DATA_WIDTH / 2;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    logic [HW-1:0]          acc_lo;
    logic [HW-1:0]          acc_hi;
    logic [HW-1:0]          s2_hi;
    logic                   s2_c1;
    logic                   s2_last;
    logic                   s2_first;
    logic                   s2_valid;
    logic                   first;
    logic                   ovf;
    logic [COUNT_WIDTH-1:0] count;

    logic                   accept;
    logic [HW-1:0]          lo_base;
    logic [HW:0]            lo_sum;
    logic [HW-1:0]          hi_base;
    logic [HW:0]            hi_sum;
    logic                   ovf_final;
    logic [COUNT_WIDTH-1:0] count_next;

    // Depends only on registers, so m_tready never reaches s_tready combinationally.
    assign s_tready = !m_tvalid && !(s2_valid && s2_last);
    assign accept   = s_tvalid && s_tready;

    always_comb begin
        lo_base    = first ? '0 : acc_lo;
        lo_sum     = {1'b0, lo_base} + {1'b0, s_tdata[HW-1:0]};
        hi_base    = s2_first ? '0 : acc_hi;
        hi_sum     = {1'b0, hi_base} + {1'b0, s2_hi} + {{HW{1'b0}}, s2_c1};
        ovf_final  = (!s2_first && ovf) || hi_sum[HW];
        count_next = first ? CNT_ONE : ((&count) ? count : count + CNT_ONE);
    end

    // Stage 1: low half plus the beat counter; the low carry rides along to stage 2.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            acc_lo   <= '0;
            s2_hi    <= '0;
            s2_c1    <= 1'b0;
            s2_last  <= 1'b0;
            s2_first <= 1'b0;
            s2_valid <= 1'b0;
            first    <= 1'b1;
            count    <= '0;
        end else begin
            s2_valid <= accept;
            if (accept) begin
                {s2_c1, acc_lo} <= lo_sum;
                s2_hi           <= s_tdata[DATA_WIDTH-1:HW];
                s2_last         <= s_tlast;
                s2_first        <= first;
                first           <= s_tlast;
                count           <= count_next;
            end
        end
    end

    // Stage 2: high half one cycle behind, with the sticky overflow.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            acc_hi <= '0;
            ovf    <= 1'b0;
        end else if (s2_valid) begin
            acc_hi <= hi_sum[HW-1:0];
            ovf    <= ovf_final;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            m_tdata  <= '0;
            m_tcount <= '0;
            m_tuser  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (s2_valid && s2_last) begin
            m_tdata  <= (SATURATE && ovf_final) ? '1 : {hi_sum[HW-1:0], acc_lo};
            m_tcount <= count;
            m_tuser  <= ovf_final;
            m_tvalid <= 1'b1;
        end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fixp_acc_stream.sv
// Bench for fixp_acc_stream: three instances (saturating, wrapping, 2-bit counter) fed the same stream.
module tb_fixp_acc_stream;

    logic         clk;
    logic         rst_n;
    logic [127:0] s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         m_tready;

    logic         rdy_s, rdy_w, rdy_c;
    logic [127:0] dat_s, dat_w, dat_c;
    logic [15:0]  cnt_s, cnt_w;
    logic [1:0]   cnt_c;
    logic         usr_s, usr_w, usr_c;
    logic         vld_s, vld_w, vld_c;

    fixp_acc_stream #(.DATA_WIDTH(128), .COUNT_WIDTH(16), .SATURATE(1'b1)) dut_s (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(rdy_s), .m_tdata(dat_s), .m_tcount(cnt_s),
        .m_tuser(usr_s), .m_tvalid(vld_s), .m_tready(m_tready));

    fixp_acc_stream #(.DATA_WIDTH(128), .COUNT_WIDTH(16), .SATURATE(1'b0)) dut_w (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(rdy_w), .m_tdata(dat_w), .m_tcount(cnt_w),
        .m_tuser(usr_w), .m_tvalid(vld_w), .m_tready(m_tready));

    fixp_acc_stream #(.DATA_WIDTH(128), .COUNT_WIDTH(2), .SATURATE(1'b1)) dut_c (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(rdy_c), .m_tdata(dat_c), .m_tcount(cnt_c),
        .m_tuser(usr_c), .m_tvalid(vld_c), .m_tready(m_tready));

    typedef struct packed {
        logic [127:0] sat;
        logic [127:0] wrap;
        logic [15:0]  cnt;
        logic [1:0]   cnt2;
        logic         user;
    } exp_t;

    typedef struct packed {
        logic [127:0] d;
        logic         last;
        exp_t         e;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop one expected result per output handshake.
    always @(negedge clk) begin
        if (vld_s && m_tready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none", dat_s);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sat_data",  dat_s, e.sat);
                chk("sat_count", cnt_s, e.cnt);
                chk("sat_user",  usr_s, e.user);
                chk("wrap_data", dat_w, e.wrap);
                chk("wrap_user", usr_w, e.user);
                chk("cw2_count", cnt_c, e.cnt2);
                chk("cw2_data",  dat_c, e.sat);
                chk("vld_align", {vld_w, vld_c}, 2'b11);
            end
        end
    end

    task automatic send(input logic [127:0] d, input logic last);
        bit ok;
        ok       = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rdy_s) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: got s_tready=0 expected 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    function automatic exp_t mk(input logic [127:0] sat, input logic [127:0] wrap,
                                input logic [15:0] cnt, input logic [1:0] cnt2, input logic user);
        exp_t e;
        e.sat = sat; e.wrap = wrap; e.cnt = cnt; e.cnt2 = cnt2; e.user = user;
        return e;
    endfunction

    task automatic addv(input logic [127:0] d, input logic last, input exp_t e);
        vec_t v;
        v.d = d; v.last = last; v.e = e;
        vt.push_back(v);
    endtask

    initial begin
        logic [127:0] ones, lo_ones, top, none;
        exp_t         nx;
        ones    = '1;
        lo_ones = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        top     = {1'b1, 127'h0};
        none    = '0;
        nx      = '0;

        addv(128'h5, 1'b1, mk(128'h5, 128'h5, 16'd1, 2'd1, 1'b0));
        addv(lo_ones, 1'b0, nx);
        addv(128'h1, 1'b1, mk({64'h1, 64'h0}, {64'h1, 64'h0}, 16'd2, 2'd2, 1'b0));
        addv(ones, 1'b0, nx);
        addv(128'h2, 1'b1, mk(ones, 128'h1, 16'd2, 2'd2, 1'b1));
        addv(128'h3, 1'b1, mk(128'h3, 128'h3, 16'd1, 2'd1, 1'b0));
        for (int i = 0; i < 4; i++) addv(128'h1, 1'b0, nx);
        addv(128'h1, 1'b1, mk(128'h5, 128'h5, 16'd5, 2'd3, 1'b0));
        addv({64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, nx);
        addv(128'h1, 1'b1, mk({64'h2, 64'h0}, {64'h2, 64'h0}, 16'd2, 2'd2, 1'b0));
        addv(top, 1'b0, nx);
        addv(top, 1'b0, nx);
        addv(top, 1'b1, mk(ones, top, 16'd3, 2'd3, 1'b1));
        addv(128'h1234_5678, 1'b0, nx);
        addv(128'h1111, 1'b1, mk(128'h1234_6789, 128'h1234_6789, 16'd2, 2'd2, 1'b0));

        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_s_tready", rdy_s, 1);
        chk("rst_m_tvalid", vld_s, 0);
        chk("rst_m_tdata",  dat_s, none);
        chk("rst_m_tcount", cnt_s, 0);
        chk("rst_m_tuser",  usr_s, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat latency and the two-cycle s_tready bubble.
        send(128'h5, 1'b1);
        sb.push_back(mk(128'h5, 128'h5, 16'd1, 2'd1, 1'b0));
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("t1_s_tready", rdy_s, 0);
        chk("t1_m_tvalid", vld_s, 0);
        @(negedge clk);
        chk("t2_s_tready", rdy_s, 0);
        chk("t2_m_tvalid", vld_s, 1);
        @(negedge clk);
        chk("t3_s_tready", rdy_s, 1);
        chk("t3_m_tvalid", vld_s, 0);
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            send(vt[i].d, vt[i].last);
            if (vt[i].last) sb.push_back(vt[i].e);
        end
        s_tvalid = 1'b0;
        drain();

        // Backpressure: result held for 5 cycles, then released.
        m_tready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(128'h10, i == 3);
        sb.push_back(mk(128'h40, 128'h40, 16'd4, 2'd3, 1'b0));
        s_tvalid = 1'b0;
        for (int i = 0; i < 20 && !vld_s; i++) @(negedge clk);
        chk("bp_m_tvalid", vld_s, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_s_tready", rdy_s, 0);
            chk("bp_hold_data", dat_s, 128'h40);
            chk("bp_hold_count", cnt_s, 4);
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_after_s_tready", rdy_s, 1);
        chk("bp_after_m_tvalid", vld_s, 0);
        drain();

        // Asynchronous reset in the middle of a packet.
        @(posedge clk);
        #1;
        send(128'h7, 1'b0);
        send(128'h9, 1'b0);
        s_tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_tready", rdy_s, 1);
        chk("mid_rst_m_tvalid", {vld_s, vld_w, vld_c}, 0);
        chk("mid_rst_m_tdata",  dat_s, none);
        chk("mid_rst_m_tcount", cnt_s, 0);
        chk("mid_rst_m_tuser",  usr_s, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(128'h4, 1'b1);
        sb.push_back(mk(128'h4, 128'h4, 16'd1, 2'd1, 1'b0));
        s_tvalid = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixp_acc_stream.md
# fixp_acc_stream

Streaming fixed-point accumulator for the 250 MHz box. It consumes an AXI-stream of unsigned fixed-point words and sums every beat of a packet into one total. The wide add is split into two registered half-width stages with a carry hand-off, so timing closes at 250 MHz. When `s_tlast` arrives it emits one result beat carrying the sum, the beat count and an overflow flag to the next stage.

## Interface
- `DATA_WIDTH`, 128: operand and sum width; must be even; split into `DATA_WIDTH/2` halves.
- `COUNT_WIDTH`, 16: beat-counter width.
- `SATURATE`, 1: 1 = result forced to all-ones on overflow; 0 = result wraps modulo 2^DATA_WIDTH.

Ports:
- `axis_aclk` in 1: single clock.
- `axis_aresetn` in 1: asynchronous, active-low reset.
- `s_tdata` in DATA_WIDTH: operand, unsigned.
- `s_tvalid` in 1: operand valid.
- `s_tlast` in 1: final beat of the packet.
- `s_tready` out 1: block accepts a beat.
- `m_tdata` out DATA_WIDTH: packet sum.
- `m_tcount` out COUNT_WIDTH: number of beats summed, saturating.
- `m_tuser` out 1: overflow occurred in this packet.
- `m_tvalid` out 1: result valid.
- `m_tready` in 1: downstream accepts the result.

## Operation
- Stage 1, on each accepted beat:
  - `{c1, acc_lo} <= acc_lo + s_tdata[lo]`.
  - `s_tdata[hi]`, `c1` and `s_tlast` are registered into stage 2; `s2_valid <= 1`.
  - On the first beat of a packet, `acc_lo` is treated as 0.
- Stage 2, when `s2_valid`:
  - `{c2, acc_hi} <= acc_hi + s2_hi + s2_c1`.
  - `c2 = 1` sets the sticky `ovf`.
  - On the first beat of a packet, `acc_hi` is treated as 0 and `ovf` as 0.
- Beat counter:
  - Loads 1 on the first beat; otherwise increments, saturating at 2^COUNT_WIDTH-1.
  - No wrap to 0.
- Stage 2 holding a last beat: the output register loads
  - `m_tdata = (SATURATE && ovf_final) ? all-ones : {acc_hi_new, acc_lo}`;
  - `m_tuser = ovf_final`;
  - `m_tcount = count`;
  - `m_tvalid <= 1`.
  - `ovf_final` includes the `c2` of that same final beat.
- `s_tready = !m_tvalid && !(s2_valid && s2_last)`: one bubble after every last beat, then stall until the result is taken.
- Single-beat packet (`s_tlast` on the first beat) is legal: result = operand, count = 1.
- Packet-start tracking:
  - A `first` flag is set at reset and after each last beat.
  - It is cleared by any accepted non-last beat.
- Inputs are ignored when `s_tvalid && !s_tready`; the upstream must hold its data.
- Reset mid-packet discards the partial sum; the next accepted beat starts a new packet.

## Timing
- Reset values:
  - `s_tready = 1`.
  - `m_tvalid = 0`, `m_tdata = 0`, `m_tcount = 0`, `m_tuser = 0`.
  - All accumulators, carries, `s2_valid` and the counter are 0; `first = 1`.
- Throughput is one beat per cycle inside a packet.
- Latency: last beat accepted in cycle T → `m_tvalid` high in T+2.
- `s_tready` is low in T+1, and stays low from T+2 until the `m_tvalid && m_tready` handshake.
- Result handshake in cycle H:
  - `m_tvalid` is low in H+1 and `s_tready` is high in H+1.
  - No combinational path from `m_tready` to `s_tready`.
- `m_tdata`, `m_tcount` and `m_tuser` are stable while `m_tvalid && !m_tready`.
- The carry between halves is delayed exactly one cycle. `acc_hi` after the stage-2 update always equals the high half of the true sum of all accepted beats.
- A minimum packet of N beats with `m_tready = 1` occupies N+2 cycles. The next packet's first beat may be accepted in T+3.

## Test plan
- Single beat, SATURATE=1, `s_tdata = 0x5`, `tlast = 1`, `m_tready = 1` → two cycles later `m_tdata = 0x5`, `m_tcount = 1`, `m_tuser = 0`. `s_tready` low for exactly 2 cycles.
- Carry across halves, DATA_WIDTH=128: beats `0x0000…0000_FFFF…FFFF` then `0x1` (last) → `m_tdata = 0x1_0000…0000`, `m_tcount = 2`, `m_tuser = 0`.
- Overflow:
  - SATURATE=1: beats all-ones then `0x2` (last) → `m_tdata` = all-ones, `m_tuser = 1`.
  - SATURATE=0: same beats → `m_tdata = 0x1`, `m_tuser = 1`.
  - Next packet `0x3` (last) → `m_tuser = 0`.
- Backpressure: 4-beat packet of `0x10` each with `m_tready = 0` for 5 cycles after `m_tvalid` → `s_tready` held low, outputs stable at `0x40` / count 4. Then `m_tready = 1`: one handshake, and `s_tready` high the next cycle.
- Reset mid-packet: accept `0x7`, `0x9` (not last), pulse `axis_aresetn` low asynchronously between edges → all outputs at reset values immediately. Then beat `0x4` (last) → `m_tdata = 0x4`, `m_tcount = 1`.
- Counter saturation, COUNT_WIDTH=2: 5-beat packet of `0x1` → `m_tdata = 0x5`, `m_tcount = 3`.
